seq_align_arbiter: RTL and testbench

Round-robin controller that shares one `sequence_aligner` instance among `N_LANES` feed lanes. Each lane delivers 0–7-bit chunks. The arbiter grants one lane at a time and holds the grant until exactly 16 bits have gone into the aligner. It splits chunks that overrun a word boundary and tags each aligned word with its source lane. It sits between the per-lane deserialisers and the aligner in the order-feed ingress path.

---
 rtl/seq_align_pkg.sv | 18 +
 rtl/seq_align_arbiter_tag_fifo.sv | 52 +++++
 rtl/seq_align_arbiter.sv | 134 +++++++++++++
 tb/tb_seq_align_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_align_pkg.sv
// Shared widths, arbiter state encoding and the chunk bit-mask helper for
// the sequence-aligner lane arbiter.
package seq_align_pkg;

  localparam int WORD_W  = 16;
  localparam int CHUNK_W = 7;
  localparam int NUM_W   = 3;

  typedef enum logic {
    IDLE,
    FILL
  } arb_state_t;

  function automatic logic [CHUNK_W-1:0] mask(input logic [NUM_W-1:0] n);
    return CHUNK_W'((1 << n) - 1);
  endfunction

endpackage

// File: rtl/seq_align_arbiter_tag_fifo.sv
// Depth-2 FIFO of source-lane tags, one per completed word, popped as the
// aligner presents each word. Popping while empty sets a sticky error.
module lane_tag_fifo #(
  parameter int LANE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [LANE_W-1:0] push_lane,
  input  logic              pop,
  output logic [LANE_W-1:0] head,
  output logic              err
);

  logic [LANE_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_lane;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
      if (pop && (count == 2'd0)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_align_arbiter.sv
// Round-robin arbiter sharing one sequence aligner among several chunk lanes;
// holds each grant for exactly one aligner word and tags words by lane.
module seq_align_arbiter
  import seq_align_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int WORD_W  = seq_align_pkg::WORD_W,
  parameter int CHUNK_W = seq_align_pkg::CHUNK_W,
  parameter int NUM_W   = seq_align_pkg::NUM_W,
  parameter int LANE_W  = $clog2(N_LANES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_LANES-1:0]         lane_en,
  input  logic [N_LANES-1:0]         req_valid,
  input  logic [N_LANES*CHUNK_W-1:0] req_seq,
  input  logic [N_LANES*NUM_W-1:0]   req_num,
  output logic [N_LANES-1:0]         req_ready,
  output logic [CHUNK_W-1:0]         al_seq,
  output logic [NUM_W-1:0]           al_num,
  input  logic                       al_out_valid,
  output logic [LANE_W-1:0]          grant_lane,
  output logic                       busy,
  output logic                       word_valid,
  output logic [LANE_W-1:0]          word_lane,
  output logic                       tag_err
);

  localparam int REM_W = $clog2(WORD_W + 1);

  arb_state_t         state;
  logic [LANE_W-1:0]  rr_ptr;
  logic [REM_W-1:0]   rem;
  logic [NUM_W-1:0]   off [N_LANES];
  logic [CHUNK_W-1:0] seq_arr [N_LANES];
  logic [NUM_W-1:0]   num_arr [N_LANES];
  logic [N_LANES-1:0] eligible;
  logic [CHUNK_W-1:0] seq_g;
  logic [NUM_W-1:0]   avail;
  logic [NUM_W-1:0]   take;
  logic               fill_step;
  logic               word_done;

  function automatic logic [LANE_W-1:0] rr_pick(input logic [LANE_W-1:0]  ptr,
                                                input logic [N_LANES-1:0] elig);
    logic [LANE_W-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      idx = (32'(ptr) + i) % N_LANES;
      if (!found && elig[idx]) begin
        pick  = LANE_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_LANES; i++) begin
      seq_arr[i] = req_seq[i*CHUNK_W +: CHUNK_W];
      num_arr[i] = req_num[i*NUM_W +: NUM_W];
    end
  end

  // Bits are consumed MSB-first; off counts bits already sent from the top.
  always_comb begin
    eligible  = lane_en & req_valid;
    seq_g     = seq_arr[grant_lane];
    avail     = num_arr[grant_lane] - off[grant_lane];
    take      = (REM_W'(avail) > rem) ? NUM_W'(rem) : avail;
    fill_step = (state == FILL) && req_valid[grant_lane];
    word_done = fill_step && (rem == REM_W'(take));
    req_ready = '0;
    al_seq    = '0;
    al_num    = '0;
    if (fill_step) begin
      al_num                = take;
      al_seq                = (seq_g & mask(avail)) >> (avail - take);
      req_ready[grant_lane] = (take == avail);
    end
  end

  assign busy       = (state == FILL);
  assign word_valid = al_out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      rem        <= REM_W'(WORD_W);
      grant_lane <= '0;
      for (int unsigned i = 0; i < N_LANES; i++) begin
        off[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            grant_lane <= rr_pick(rr_ptr, eligible);
            rem        <= REM_W'(WORD_W);
            state      <= FILL;
          end
        end
        FILL: begin
          if (fill_step) begin
            off[grant_lane] <= (take == avail) ? '0 : off[grant_lane] + take;
            rem             <= rem - REM_W'(take);
            if (word_done) begin
              rr_ptr <= (grant_lane == LANE_W'(N_LANES - 1)) ? '0 : grant_lane + 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  lane_tag_fifo #(
    .LANE_W(LANE_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (word_done),
    .push_lane(grant_lane),
    .pop      (al_out_valid),
    .head     (word_lane),
    .err      (tag_err)
  );

endmodule

// File: tb/tb_seq_align_arbiter.sv
// Directed bench for seq_align_arbiter: splitting, round-robin, lane enable,
// stalls, mid-word reset and the tag-underflow error.
module tb_seq_align_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  lane_en;
  logic [3:0]  req_valid;
  logic [27:0] req_seq;
  logic [11:0] req_num;
  logic [3:0]  req_ready;
  logic [6:0]  al_seq;
  logic [2:0]  al_num;
  logic        al_out_valid;
  logic [1:0]  grant_lane;
  logic        busy;
  logic        word_valid;
  logic [1:0]  word_lane;
  logic        tag_err;

  logic [6:0]  lseq [4];
  logic [2:0]  lnum [4];

  int errors = 0;
  int checks = 0;

  assign req_seq = {lseq[3], lseq[2], lseq[1], lseq[0]};
  assign req_num = {lnum[3], lnum[2], lnum[1], lnum[0]};

  always #5 clk = ~clk;

  seq_align_arbiter #(
    .N_LANES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lane_en     (lane_en),
    .req_valid   (req_valid),
    .req_seq     (req_seq),
    .req_num     (req_num),
    .req_ready   (req_ready),
    .al_seq      (al_seq),
    .al_num      (al_num),
    .al_out_valid(al_out_valid),
    .grant_lane  (grant_lane),
    .busy        (busy),
    .word_valid  (word_valid),
    .word_lane   (word_lane),
    .tag_err     (tag_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    lane_en      = '0;
    req_valid    = '0;
    al_out_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lseq[i] = '0;
      lnum[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    lane_en = '1; req_valid = '1; al_out_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin lseq[i] = 7'h7F; lnum[i] = 3'd7; end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    checks++; if (al_seq !== 7'd0) begin errors++; $display("FAIL rst_al_seq got=%h exp=0", al_seq); end
    checks++; if (al_num !== 3'd0) begin errors++; $display("FAIL rst_al_num got=%0d exp=0", al_num); end
    checks++; if (grant_lane !== 2'd0) begin errors++; $display("FAIL rst_grant got=%0d exp=0", grant_lane); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (word_lane !== 2'd0) begin errors++; $display("FAIL rst_word_lane got=%0d exp=0", word_lane); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL rst_tag_err got=%b exp=0", tag_err); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rst_word_valid got=%b exp=1", word_valid); end
    al_out_valid = 1'b0;
    #1;
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_word_valid_lo got=%b exp=0", word_valid); end
  endtask

  task automatic test_split();
    do_reset();
    lane_en = 4'b0001; req_valid = 4'b0001;
    lseq[0] = 7'b1111111; lnum[0] = 3'd7;
    step();
    checks++; if (busy !== 1'b1 || grant_lane !== 2'd0) begin errors++; $display("FAIL split_grant busy=%b lane=%0d exp busy=1 lane=0", busy, grant_lane); end
    checks++; if (al_num !== 3'd7 || al_seq !== 7'b1111111) begin errors++; $display("FAIL split_c0 got=%0d/%b exp=7/1111111", al_num, al_seq); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL split_c0_ready got=%b exp=0001", req_ready); end
    step();
    lseq[0] = 7'b1000011; lnum[0] = 3'd7;
    #1;
    checks++; if (al_num !== 3'd7 || al_seq !== 7'b1000011) begin errors++; $display("FAIL split_c1 got=%0d/%b exp=7/1000011", al_num, al_seq); end
    step();
    lseq[0] = 7'b0000110; lnum[0] = 3'd3;
    #1;
    checks++; if (al_num !== 3'd2 || al_seq !== 7'b0000011) begin errors++; $display("FAIL split_c2 got=%0d/%b exp=2/0000011", al_num, al_seq); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL split_c2_ready got=%b exp=0000", req_ready); end
    step();
    checks++; if (busy !== 1'b0 || al_num !== 3'd0) begin errors++; $display("FAIL split_idle busy=%b num=%0d exp busy=0 num=0", busy, al_num); end
    al_out_valid = 1'b1;
    #1;
    checks++; if (word_valid !== 1'b1 || word_lane !== 2'd0) begin errors++; $display("FAIL split_tag valid=%b lane=%0d exp 1/0", word_valid, word_lane); end
    step();
    al_out_valid = 1'b0;
    checks++; if (al_num !== 3'd1 || al_seq !== 7'b0000000) begin errors++; $display("FAIL split_rest got=%0d/%b exp=1/0000000", al_num, al_seq); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL split_rest_ready got=%b exp=0001", req_ready); end
    step();
    lseq[0] = 7'b1010101; lnum[0] = 3'd7;
    #1;
    checks++; if (al_num !== 3'd7 || al_seq !== 7'b1010101) begin errors++; $display("FAIL split_after got=%0d/%b exp=7/1010101", al_num, al_seq); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL split_tag_err got=%b exp=0", tag_err); end
  endtask

  task automatic test_two_lanes();
    int exp_lane [4] = '{0, 2, 0, 2};
    int n;
    do_reset();
    lane_en = 4'b0101; req_valid = 4'b0101;
    lseq[0] = 7'h55; lnum[0] = 3'd7;
    lseq[2] = 7'h2A; lnum[2] = 3'd7;
    for (int w = 0; w < 4; w++) begin
      n = 0;
      while (!busy && n < 20) begin step(); n++; end
      checks++; if (busy !== 1'b1 || grant_lane !== 2'(exp_lane[w])) begin errors++; $display("FAIL rr_grant%0d busy=%b lane=%0d exp lane=%0d", w, busy, grant_lane, exp_lane[w]); end
      n = 0;
      while (busy && n < 20) begin step(); n++; end
      checks++; if (n !== 3) begin errors++; $display("FAIL rr_fill_cycles%0d got=%0d exp=3", w, n); end
      al_out_valid = 1'b1;
      #1;
      checks++; if (word_lane !== 2'(exp_lane[w])) begin errors++; $display("FAIL rr_word_lane%0d got=%0d exp=%0d", w, word_lane, exp_lane[w]); end
      step();
      al_out_valid = 1'b0;
    end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL rr_tag_err got=%b exp=0", tag_err); end
  endtask

  task automatic test_lane_en();
    int exp_lane [4] = '{1, 2, 3, 2};
    int n;
    do_reset();
    lane_en = 4'b1110; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin lseq[i] = 7'h7F; lnum[i] = 3'd7; end
    for (int w = 0; w < 4; w++) begin
      n = 0;
      while (!busy && n < 20) begin step(); n++; end
      checks++; if (busy !== 1'b1 || grant_lane !== 2'(exp_lane[w])) begin errors++; $display("FAIL en_grant%0d busy=%b lane=%0d exp lane=%0d", w, busy, grant_lane, exp_lane[w]); end
      n = 0;
      while (busy && n < 20) begin
        step(); n++;
        if (w == 0 && n == 1) lane_en = 4'b1100;
      end
      if (w == 0) begin
        checks++; if (n !== 3) begin errors++; $display("FAIL en_word_done got=%0d cycles exp=3", n); end
      end
      al_out_valid = 1'b1;
      #1;
      checks++; if (word_lane !== 2'(exp_lane[w])) begin errors++; $display("FAIL en_word_lane%0d got=%0d exp=%0d", w, word_lane, exp_lane[w]); end
      step();
      al_out_valid = 1'b0;
    end
  endtask

  task automatic test_stall();
    do_reset();
    lane_en = 4'b0011; req_valid = 4'b0011;
    lseq[0] = 7'h7F; lnum[0] = 3'd7;
    lseq[1] = 7'h33; lnum[1] = 3'd7;
    step();
    checks++; if (grant_lane !== 2'd0 || al_num !== 3'd7) begin errors++; $display("FAIL stall_first lane=%0d num=%0d exp 0/7", grant_lane, al_num); end
    step();
    req_valid = 4'b0010;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (al_num !== 3'd0 || req_ready !== 4'b0000) begin errors++; $display("FAIL stall_hold%0d num=%0d ready=%b exp 0/0000", i, al_num, req_ready); end
      checks++; if (busy !== 1'b1 || grant_lane !== 2'd0) begin errors++; $display("FAIL stall_grant%0d busy=%b lane=%0d exp 1/0", i, busy, grant_lane); end
      step();
    end
    req_valid = 4'b0011;
    #1;
    checks++; if (al_num !== 3'd7 || req_ready !== 4'b0001) begin errors++; $display("FAIL stall_resume num=%0d ready=%b exp 7/0001", al_num, req_ready); end
    step();
    checks++; if (al_num !== 3'd2 || req_ready !== 4'b0000) begin errors++; $display("FAIL stall_last num=%0d ready=%b exp 2/0000", al_num, req_ready); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_done busy=%b exp=0", busy); end
    al_out_valid = 1'b1;
    #1;
    checks++; if (word_lane !== 2'd0) begin errors++; $display("FAIL stall_word_lane got=%0d exp=0", word_lane); end
    step();
    al_out_valid = 1'b0;
    checks++; if (grant_lane !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL stall_next lane=%0d busy=%b exp 1/1", grant_lane, busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lane_en = 4'b0001; req_valid = 4'b0001;
    lseq[0] = 7'h7F; lnum[0] = 3'd7;
    step();
    step();
    step();
    lseq[0] = 7'b0000110; lnum[0] = 3'd3;
    #1;
    checks++; if (al_num !== 3'd2) begin errors++; $display("FAIL rmid_split num=%0d exp=2", al_num); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || grant_lane !== 2'd0 || al_num !== 3'd0 || al_seq !== 7'd0 || req_ready !== 4'd0) begin
      errors++; $display("FAIL rmid_rst_a busy=%b lane=%0d num=%0d seq=%h ready=%b exp all 0", busy, grant_lane, al_num, al_seq, req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (al_num !== 3'd3 || al_seq !== 7'b0000110 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL rmid_off_clear num=%0d seq=%b ready=%b exp 3/0000110/0001", al_num, al_seq, req_ready);
    end
    step();
    lseq[0] = 7'b0111111; lnum[0] = 3'd6;
    #1;
    checks++; if (al_num !== 3'd6) begin errors++; $display("FAIL rmid_6bit num=%0d exp=6", al_num); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || al_num !== 3'd0 || req_ready !== 4'd0 || word_lane !== 2'd0 || tag_err !== 1'b0) begin
      errors++; $display("FAIL rmid_rst_b busy=%b num=%0d ready=%b wl=%0d err=%b exp all 0", busy, al_num, req_ready, word_lane, tag_err);
    end
    @(negedge clk);
    rst = 1'b1;
    lseq[0] = 7'h7F; lnum[0] = 3'd7;
    step();
    checks++; if (al_num !== 3'd7 || busy !== 1'b1) begin errors++; $display("FAIL rmid_new0 num=%0d busy=%b exp 7/1", al_num, busy); end
    step();
    step();
    checks++; if (al_num !== 3'd2 || al_seq !== 7'b0000011 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rmid_new2 num=%0d seq=%b ready=%b exp 2/0000011/0000", al_num, al_seq, req_ready);
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_done busy=%b exp=0", busy); end
  endtask

  task automatic test_tag_err();
    do_reset();
    al_out_valid = 1'b1;
    #1;
    checks++; if (tag_err !== 1'b0 || word_valid !== 1'b1) begin errors++; $display("FAIL terr_pre err=%b wv=%b exp 0/1", tag_err, word_valid); end
    step();
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL terr_set got=%b exp=1", tag_err); end
    al_out_valid = 1'b0;
    step();
    step();
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL terr_sticky got=%b exp=1", tag_err); end
    rst = 1'b0;
    #1;
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL terr_clear got=%b exp=0", tag_err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_split();
    test_two_lanes();
    test_lane_en();
    test_stall();
    test_reset_mid();
    test_tag_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
